// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the step-counter width helper.
package seq_restoring_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Encoding is fixed so the debug state output decodes the same way in
    // every build: IDLE=0, RUN=1, DONE=2.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count down from width-1 to 0 (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and keep the difference
// only when it did not go negative.
module div_step
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;

    // Shift {r,q} left by one with the dividend bit entering r, then decide
    // the new quotient bit from the sign of the widened trial difference.
    // The partial remainder is always below 2**(WIDTH-1) before the shift,
    // so nothing is lost off the top of r.
    always_comb begin
        r_sh  = (r << 1) | {{(WIDTH-1){1'b0}}, din};
        q_sh  = q << 1;
        trial = {1'b0, r_sh} - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_next = r_sh;
            q_next = q_sh;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// busy=0 (IDLE or DONE state); dividend/divisor are sampled on that edge
// only. While busy=1, start is ignored. done pulses high for exactly one
// cycle, and quotient/remainder/div_by_zero are valid from that cycle until
// the next completion. A start in the done cycle is accepted back-to-back.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] a_q, a_n;      // dividend, consumed MSB first
    logic [WIDTH-1:0] d_q, d_n;      // latched divisor
    logic [WIDTH-1:0] r_q, r_n;      // partial remainder
    logic [WIDTH-1:0] q_q, q_n;      // partial quotient
    logic             busy_n, done_n, dbz_n;
    logic [WIDTH-1:0] quo_n, rem_n;
    logic [WIDTH-1:0] step_r, step_q;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r      (r_q),
        .q      (q_q),
        .din    (a_q[WIDTH-1]),
        .divisor(d_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-datapath decode. A zero divisor skips the
    // iterations: the first RUN cycle goes straight to DONE with the
    // saturated quotient and the untouched dividend as remainder.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        d_n     = d_q;
        r_n     = r_q;
        q_n     = q_q;
        busy_n  = busy;
        done_n  = 1'b0;
        quo_n   = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (start) begin
                    a_n     = dividend;
                    d_n     = divisor;
                    r_n     = '0;
                    q_n     = '0;
                    cnt_n   = CW'(WIDTH-1);
                    busy_n  = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (d_q == '0) begin
                    quo_n   = '1;
                    rem_n   = a_q;
                    dbz_n   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_DONE;
                end else begin
                    a_n   = a_q << 1;
                    r_n   = step_r;
                    q_n   = step_q;
                    cnt_n = cnt - CW'(1);
                    if (cnt == '0) begin
                        quo_n   = step_q;
                        rem_n   = step_r;
                        dbz_n   = 1'b0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_DONE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            a_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            a_q         <= a_n;
            d_q         <= d_n;
            r_q         <= r_n;
            q_q         <= q_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=4): hand-computed
// vectors, back-to-back, zero divisor, ignored start, async reset and a
// full operand sweep against an a/b, a%b reference.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    // Expected {div_by_zero, quotient, remainder} per issued division.
    logic [2*W:0] exp_q[$];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_res(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_q.push_back({dbz, q, r});
    endtask

    // Drive one start pulse; returns just after the sampling edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency and results.
    task automatic collect(input string tag, input int exp_lat);
        int lat;
        logic [2*W:0] e;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < 20);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s.queue: observed empty expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".quotient"}, quotient, e[2*W-1:W]);
            check({tag, ".remainder"}, remainder, e[W-1:0]);
            check({tag, ".div_by_zero"}, div_by_zero, e[2*W]);
        end
    endtask

    initial begin
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state.
        #3;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.quotient", quotient, 0);
        check("rst.remainder", remainder, 0);
        check("rst.div_by_zero", div_by_zero, 0);
        check("rst.state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 13/3 -> q=4 r=1, busy for 4 cycles.
        d0 = done_cnt;
        expect_res(4'd4, 4'd1, 1'b0);
        issue(4'd13, 4'd3);
        check("t1.busy_e0", busy, 1);
        check("t1.done_e0", done, 0);
        check("t1.state_e0", dbg_state, 1);
        collect("t1", 4);
        @(posedge clk);
        #1;
        check("t1.done_drops", done, 0);
        check("t1.q_holds", quotient, 4);
        check("t1.pulses", done_cnt - d0, 1);

        // 15/1 then 2/7 back-to-back.
        d0 = done_cnt;
        expect_res(4'd15, 4'd0, 1'b0);
        issue(4'd15, 4'd1);
        collect("t2a", 4);
        expect_res(4'd0, 4'd2, 1'b0);
        issue(4'd2, 4'd7);
        check("t2b.done_e0", done, 0);
        check("t2b.busy_e0", busy, 1);
        collect("t2b", 4);
        @(posedge clk);
        #1;
        check("t2.pulses", done_cnt - d0, 2);

        // 5/0 -> saturated quotient, then 9/3 clears div_by_zero.
        expect_res(4'd15, 4'd5, 1'b1);
        issue(4'd5, 4'd0);
        check("t3a.busy_e0", busy, 1);
        collect("t3a", 1);
        @(posedge clk);
        #1;
        expect_res(4'd3, 4'd0, 1'b0);
        issue(4'd9, 4'd3);
        collect("t3b", 4);

        // 12/4 with a 7/2 start pulsed while busy -> ignored.
        @(posedge clk);
        #1;
        d0 = done_cnt;
        expect_res(4'd3, 4'd0, 1'b0);
        issue(4'd12, 4'd4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        collect("t4", 1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("t4.busy_after", busy, 0);
        check("t4.pulses", done_cnt - d0, 1);

        // 14/3 interrupted by async reset after E2, then rerun.
        d0 = done_cnt;
        issue(4'd14, 4'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2;
        rst = 1'b1;
        #1;
        check("t5.rst_busy", busy, 0);
        check("t5.rst_done", done, 0);
        check("t5.rst_quotient", quotient, 0);
        check("t5.rst_remainder", remainder, 0);
        check("t5.rst_dbz", div_by_zero, 0);
        check("t5.rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("t5.no_done", done_cnt - d0, 0);
        expect_res(4'd4, 4'd2, 1'b0);
        issue(4'd14, 4'd3);
        collect("t5", 4);

        // Full operand sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    expect_res(4'hF, W'(a), 1'b1);
                end else begin
                    expect_res(W'(a / b), W'(a % b), 1'b0);
                end
                issue(W'(a), W'(b));
                collect($sformatf("sweep_%0d_%0d", a, b), (b == 0) ? 1 : W);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
